trackball_position_counter: RTL and testbench

// - Trackball end of the position-control interface. It decodes two quadrature channels
//   (ch0, ch1) into up/down position counters.
// - It loads, clears and serially shifts those counts under the LD1n/LD2n, CL1n/CL2n,

---
 rtl/trackball_pkg.sv | 14 +
 rtl/trackball_position_counter_if.sv | 21 ++
 rtl/quad_step_decoder.sv | 65 ++++++
 rtl/trackball_position_counter.sv | 89 ++++++++
 tb/tb_trackball_position_counter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trackball_pkg.sv
// Shared types and constants for the trackball position counter.
// step_t carries one decoded count event from a channel decoder to its counter.
package trackball_pkg;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DN
  } step_t;

  localparam int   TB_WIDTH      = 8;
  localparam logic TB_IDLE_SDATA = 1'b1;

endpackage

// File: rtl/trackball_position_counter_if.sv
// Strobes, quadrature inputs and outputs between the position-control block and the counter.
// master drives quadrature phases and strobes; slave returns SDATA and the live counts.
interface trackball_position_counter_if #(
  parameter int WIDTH = 8
);
  logic             QA0, QB0, QA1, QB1;
  logic             LD1n, LD2n, CL1n, CL2n;
  logic             SHFT0, SHFT1, CK1;
  logic             SDATA;
  logic [WIDTH-1:0] POS0, POS1;

  modport master (
    output QA0, QB0, QA1, QB1, LD1n, LD2n, CL1n, CL2n, SHFT0, SHFT1, CK1,
    input  SDATA, POS0, POS1
  );

  modport slave (
    input  QA0, QB0, QA1, QB1, LD1n, LD2n, CL1n, CL2n, SHFT0, SHFT1, CK1,
    output SDATA, POS0, POS1
  );
endinterface

// File: rtl/quad_step_decoder.sv
// One quadrature channel: 2-flop sync, Gray-step decode and COUNT_DIV prescale into step_t.
// A physical edge yields a step on the 3rd ce after it; nothing advances while ce=0.
module quad_step_decoder
  import trackball_pkg::*;
#(
  parameter int COUNT_DIV = 1
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  ce,
  input  logic  qa,
  input  logic  qb,
  output step_t step
);

  localparam logic signed [3:0] DIV = 4'(COUNT_DIV);

  logic        [1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic signed [3:0] acc_q, acc_d, edge_dir, acc_sum;

  always_comb begin
    sync1_d  = sync1_q;
    sync2_d  = sync2_q;
    prev_d   = prev_q;
    acc_d    = acc_q;
    step     = STEP_NONE;
    edge_dir = 4'sd0;
    // Both phases changing together is treated as noise: prev still follows, no count.
    case ({prev_q, sync2_q})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: edge_dir = 4'sd1;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: edge_dir = -4'sd1;
      default:                                edge_dir = 4'sd0;
    endcase
    acc_sum = acc_q + edge_dir;
    if (ce) begin
      sync1_d = {qa, qb};
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      if (acc_sum >= DIV) begin
        step  = STEP_UP;
        acc_d = 4'sd0;
      end else if (acc_sum <= -DIV) begin
        step  = STEP_DN;
        acc_d = 4'sd0;
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      prev_q  <= 2'b00;
      acc_q   <= 4'sd0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: rtl/trackball_position_counter.sv
// Two-channel trackball counters with load/clear strobes and a CK1-driven serial readout on SDATA.
// Counts wrap by default; define TRACKBALL_SAT_EN for signed saturating counters.
module trackball_position_counter
  import trackball_pkg::*;
#(
  parameter int WIDTH     = TB_WIDTH,
  parameter int COUNT_DIV = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ce,
  trackball_position_counter_if.slave bus
);

`ifdef TRACKBALL_SAT_EN
  localparam logic [WIDTH-1:0] CNT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] CNT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  step_t            step0, step1;
  logic [WIDTH-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [WIDTH-1:0] sr0_q, sr0_d, sr1_q, sr1_d;
  logic             ck1_prev_q, ck1_prev_d, sdata_q, sdata_d, ck1_rise;

  function automatic logic [WIDTH-1:0] apply_step(input logic [WIDTH-1:0] base, input step_t s);
    apply_step = base;
`ifdef TRACKBALL_SAT_EN
    if (s == STEP_UP && base != CNT_MAX)      apply_step = base + 1'b1;
    else if (s == STEP_DN && base != CNT_MIN) apply_step = base - 1'b1;
`else
    if (s == STEP_UP)      apply_step = base + 1'b1;
    else if (s == STEP_DN) apply_step = base - 1'b1;
`endif
  endfunction

  quad_step_decoder #(.COUNT_DIV(COUNT_DIV)) u_dec0 (
    .clk(clk), .reset(reset), .ce(ce), .qa(bus.QA0), .qb(bus.QB0), .step(step0)
  );

  quad_step_decoder #(.COUNT_DIV(COUNT_DIV)) u_dec1 (
    .clk(clk), .reset(reset), .ce(ce), .qa(bus.QA1), .qb(bus.QB1), .step(step1)
  );

  always_comb begin
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    sr0_d      = sr0_q;
    sr1_d      = sr1_q;
    ck1_prev_d = ck1_prev_q;
    sdata_d    = sdata_q;
    ck1_rise   = bus.CK1 & ~ck1_prev_q;
    if (ce) begin
      ck1_prev_d = bus.CK1;
      // Clear restarts from zero but keeps this ce's step, so no motion is lost.
      cnt0_d = apply_step(bus.CL1n ? cnt0_q : '0, step0);
      cnt1_d = apply_step(bus.CL2n ? cnt1_q : '0, step1);
      if (!bus.LD1n)                      sr0_d = cnt0_q;
      else if (ck1_rise && !bus.SHFT0)    sr0_d = {sr0_q[WIDTH-2:0], 1'b0};
      if (!bus.LD2n)                      sr1_d = cnt1_q;
      else if (ck1_rise && !bus.SHFT1 && bus.SHFT0) sr1_d = {sr1_q[WIDTH-2:0], 1'b0};
      if (!bus.SHFT0)      sdata_d = sr0_q[WIDTH-1];
      else if (!bus.SHFT1) sdata_d = sr1_q[WIDTH-1];
      else                 sdata_d = TB_IDLE_SDATA;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      sr0_q      <= '0;
      sr1_q      <= '0;
      ck1_prev_q <= 1'b1;
      sdata_q    <= TB_IDLE_SDATA;
    end else begin
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
      sr0_q      <= sr0_d;
      sr1_q      <= sr1_d;
      ck1_prev_q <= ck1_prev_d;
      sdata_q    <= sdata_d;
    end
  end

  assign bus.SDATA = sdata_q;
  assign bus.POS0  = cnt0_q;
  assign bus.POS1  = cnt1_q;

endmodule

// File: tb/tb_trackball_position_counter.sv
// Bench for trackball_position_counter: COUNT_DIV=1 and COUNT_DIV=4 instances on one clock.
// Expected values are queued as stimulus is applied and popped when the output is sampled.
module tb_trackball_position_counter;
  import trackball_pkg::*;

  logic clk = 1'b0;
  logic reset, ce;
  always #5 clk = ~clk;

  trackball_position_counter_if #(.WIDTH(8)) bus  ();
  trackball_position_counter_if #(.WIDTH(8)) bus4 ();

  trackball_position_counter #(.WIDTH(8), .COUNT_DIV(1)) dut (
    .clk(clk), .reset(reset), .ce(ce), .bus(bus)
  );
  trackball_position_counter #(.WIDTH(8), .COUNT_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .ce(ce), .bus(bus4)
  );

  int         tests_run = 0;
  int         fails     = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e;
  logic [1:0] gray[4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int         ph[3]   = '{0, 0, 0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic drive_idle();
    {bus.QA0, bus.QB0, bus.QA1, bus.QB1}     = 4'b0000;
    {bus.LD1n, bus.LD2n, bus.CL1n, bus.CL2n} = 4'b1111;
    {bus.SHFT0, bus.SHFT1, bus.CK1}          = 3'b110;
    {bus4.QA0, bus4.QB0, bus4.QA1, bus4.QB1}     = 4'b0000;
    {bus4.LD1n, bus4.LD2n, bus4.CL1n, bus4.CL2n} = 4'b1111;
    {bus4.SHFT0, bus4.SHFT1, bus4.CK1}          = 3'b110;
    ph = '{0, 0, 0};
  endtask

  // ch 0/1 are the main DUT channels, ch 2 is channel 0 of the divide-by-4 DUT.
  task automatic step_ch(input int ch, input bit fwd);
    ph[ch] = fwd ? (ph[ch] + 1) % 4 : (ph[ch] + 3) % 4;
    case (ch)
      0:       {bus.QA0, bus.QB0}   = gray[ph[ch]];
      1:       {bus.QA1, bus.QB1}   = gray[ph[ch]];
      default: {bus4.QA0, bus4.QB0} = gray[ph[ch]];
    endcase
    tick();
  endtask

  task automatic ck1_edge();
    bus.CK1 = 1'b1;
    tick();
    bus.CK1 = 1'b0;
    tick();
  endtask

  task automatic clear_ch(input int ch);
    ticks(3);
    if (ch == 0) bus.CL1n = 1'b0; else bus.CL2n = 1'b0;
    tick();
    bus.CL1n = 1'b1;
    bus.CL2n = 1'b1;
  endtask

  task automatic test_reset();
    ce = 1'b1;
    drive_idle();
    reset = 1'b1;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    ticks(2);
    reset = 1'b0;
    e = exp_q.pop_front(); tests_run++;
    if (bus.POS0 !== e) begin fails++; $display("FAIL reset_pos0: got %h expected %h", bus.POS0, e); end
    e = exp_q.pop_front(); tests_run++;
    if (bus.POS1 !== e) begin fails++; $display("FAIL reset_pos1: got %h expected %h", bus.POS1, e); end
    e = exp_q.pop_front(); tests_run++;
    if (bus.SDATA !== e[0]) begin fails++; $display("FAIL reset_sdata: got %b expected %b", bus.SDATA, e[0]); end
  endtask

  task automatic test_forward();
    exp_q.push_back(8'h04); exp_q.push_back(8'h05); exp_q.push_back(8'h00);
    repeat (5) step_ch(0, 1'b1);
    tick();
    e = exp_q.pop_front(); tests_run++;
    if (bus.POS0 !== e) begin fails++; $display("FAIL fwd_latency_2ce: got %h expected %h", bus.POS0, e); end
    tick();
    e = exp_q.pop_front(); tests_run++;
    if (bus.POS0 !== e) begin fails++; $display("FAIL fwd_pos0: got %h expected %h", bus.POS0, e); end
    e = exp_q.pop_front(); tests_run++;
    if (bus.POS1 !== e) begin fails++; $display("FAIL fwd_pos1: got %h expected %h", bus.POS1, e); end
  endtask

  task automatic test_ce_gating();
    exp_q.push_back(8'h05); exp_q.push_back(8'h06);
    ce = 1'b0;
    step_ch(0, 1'b1);
    ticks(5);
    e = exp_q.pop_front(); tests_run++;
    if (bus.POS0 !== e) begin fails++; $display("FAIL ce_hold: got %h expected %h", bus.POS0, e); end
    ce = 1'b1;
    ticks(3);
    e = exp_q.pop_front(); tests_run++;
    if (bus.POS0 !== e) begin fails++; $display("FAIL ce_resume: got %h expected %h", bus.POS0, e); end
  endtask

  task automatic test_wrap();
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    clear_ch(0);
    e = exp_q.pop_front(); tests_run++;
    if (bus.POS0 !== e) begin fails++; $display("FAIL clear_pos0: got %h expected %h", bus.POS0, e); end
    step_ch(0, 1'b0);
    ticks(3);
    e = exp_q.pop_front(); tests_run++;
    if (bus.POS0 !== e) begin fails++; $display("FAIL wrap_down: got %h expected %h", bus.POS0, e); end
`ifdef TRACKBALL_SAT_EN
    exp_q.push_back(8'h80); exp_q.push_back(8'h80);
    repeat (127) step_ch(0, 1'b0);
    ticks(3);
    e = exp_q.pop_front(); tests_run++;
    if (bus.POS0 !== e) begin fails++; $display("FAIL sat_min: got %h expected %h", bus.POS0, e); end
    step_ch(0, 1'b0);
    ticks(3);
    e = exp_q.pop_front(); tests_run++;
    if (bus.POS0 !== e) begin fails++; $display("FAIL sat_hold: got %h expected %h", bus.POS0, e); end
`endif
  endtask

  task automatic test_load_shift();
    logic [7:0] v = 8'hA5;
    clear_ch(0);
    exp_q.push_back(8'hA5);
    repeat (91) step_ch(0, 1'b0);
    ticks(3);
    e = exp_q.pop_front(); tests_run++;
    if (bus.POS0 !== e) begin fails++; $display("FAIL a5_pos0: got %h expected %h", bus.POS0, e); end
    for (int i = 7; i >= 0; i--) exp_q.push_back({7'd0, v[i]});
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    bus.LD1n = 1'b0; tick(); bus.LD1n = 1'b1;
    bus.SHFT0 = 1'b0; tick();
    for (int i = 0; i < 10; i++) begin
      e = exp_q.pop_front(); tests_run++;
      if (bus.SDATA !== e[0]) begin
        fails++; $display("FAIL a5_shift_bit%0d: got %b expected %b", i, bus.SDATA, e[0]);
      end
      if (i < 9) ck1_edge();
    end
    bus.SHFT0 = 1'b1;
  endtask

  task automatic test_load_clear();
    logic [7:0] v = 8'h3C;
    clear_ch(0);
    exp_q.push_back(8'h3C); exp_q.push_back(8'h01);
    repeat (60) step_ch(0, 1'b1);
    ticks(3);
    e = exp_q.pop_front(); tests_run++;
    if (bus.POS0 !== e) begin fails++; $display("FAIL 3c_pos0: got %h expected %h", bus.POS0, e); end
    step_ch(0, 1'b1);
    tick();
    bus.LD1n = 1'b0; bus.CL1n = 1'b0; tick(); bus.LD1n = 1'b1; bus.CL1n = 1'b1;
    ticks(2);
    e = exp_q.pop_front(); tests_run++;
    if (bus.POS0 !== e) begin fails++; $display("FAIL ldcl_pos0: got %h expected %h", bus.POS0, e); end
    for (int i = 7; i >= 0; i--) exp_q.push_back({7'd0, v[i]});
    bus.SHFT0 = 1'b0; tick();
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front(); tests_run++;
      if (bus.SDATA !== e[0]) begin
        fails++; $display("FAIL ldcl_sr_bit%0d: got %b expected %b", i, bus.SDATA, e[0]);
      end
      ck1_edge();
    end
    bus.SHFT0 = 1'b1;
  endtask

  task automatic test_illegal();
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    {bus.QA1, bus.QB1} = 2'b11;
    ticks(5);
    e = exp_q.pop_front(); tests_run++;
    if (bus.POS1 !== e) begin fails++; $display("FAIL illegal_nocount: got %h expected %h", bus.POS1, e); end
    // 11 -> 01 is a reverse step only if prev tracked the illegal 11.
    {bus.QA1, bus.QB1} = 2'b01;
    ph[1] = 1;
    ticks(5);
    e = exp_q.pop_front(); tests_run++;
    if (bus.POS1 !== e) begin fails++; $display("FAIL illegal_prev: got %h expected %h", bus.POS1, e); end
  endtask

  task automatic test_div4();
    exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    repeat (3) step_ch(2, 1'b1);
    ticks(4);
    e = exp_q.pop_front(); tests_run++;
    if (bus4.POS0 !== e) begin fails++; $display("FAIL div4_3edges: got %h expected %h", bus4.POS0, e); end
    step_ch(2, 1'b1);
    ticks(4);
    e = exp_q.pop_front(); tests_run++;
    if (bus4.POS0 !== e) begin fails++; $display("FAIL div4_4edges: got %h expected %h", bus4.POS0, e); end
    repeat (2) step_ch(2, 1'b1);
    step_ch(2, 1'b0);
    repeat (2) step_ch(2, 1'b1);
    ticks(4);
    e = exp_q.pop_front(); tests_run++;
    if (bus4.POS0 !== e) begin fails++; $display("FAIL div4_reversal_hold: got %h expected %h", bus4.POS0, e); end
    step_ch(2, 1'b1);
    ticks(4);
    e = exp_q.pop_front(); tests_run++;
    if (bus4.POS0 !== e) begin fails++; $display("FAIL div4_reversal_count: got %h expected %h", bus4.POS0, e); end
  endtask

  task automatic test_both_shift_reset();
    clear_ch(0);
    clear_ch(1);
    exp_q.push_back(8'h80); exp_q.push_back(8'h40);
    repeat (128) step_ch(0, 1'b0);
    repeat (64) step_ch(1, 1'b1);
    ticks(3);
    e = exp_q.pop_front(); tests_run++;
    if (bus.POS0 !== e) begin fails++; $display("FAIL both_pos0: got %h expected %h", bus.POS0, e); end
    e = exp_q.pop_front(); tests_run++;
    if (bus.POS1 !== e) begin fails++; $display("FAIL both_pos1: got %h expected %h", bus.POS1, e); end
    exp_q.push_back(8'h01); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    bus.LD1n = 1'b0; bus.LD2n = 1'b0; tick(); bus.LD1n = 1'b1; bus.LD2n = 1'b1;
    bus.SHFT0 = 1'b0; bus.SHFT1 = 1'b0; tick();
    e = exp_q.pop_front(); tests_run++;
    if (bus.SDATA !== e[0]) begin fails++; $display("FAIL both_sel_ch0: got %b expected %b", bus.SDATA, e[0]); end
    ck1_edge();
    e = exp_q.pop_front(); tests_run++;
    if (bus.SDATA !== e[0]) begin fails++; $display("FAIL both_ch0_shift: got %b expected %b", bus.SDATA, e[0]); end
    bus.SHFT0 = 1'b1; tick();
    e = exp_q.pop_front(); tests_run++;
    if (bus.SDATA !== e[0]) begin fails++; $display("FAIL both_ch1_unshifted: got %b expected %b", bus.SDATA, e[0]); end
    ck1_edge();
    e = exp_q.pop_front(); tests_run++;
    if (bus.SDATA !== e[0]) begin fails++; $display("FAIL ch1_shift: got %b expected %b", bus.SDATA, e[0]); end
    bus.SHFT1 = 1'b1;
    // Reload ch0 with 80, shift partway, then reset.
    exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    bus.LD1n = 1'b0; tick(); bus.LD1n = 1'b1;
    bus.SHFT0 = 1'b0; tick();
    ck1_edge();
    {bus.QA0, bus.QB0, bus.QA1, bus.QB1} = 4'b0000;
    ph = '{0, 0, 0};
    reset = 1'b1; tick();
    e = exp_q.pop_front(); tests_run++;
    if (bus.SDATA !== e[0]) begin fails++; $display("FAIL midshift_reset_sdata: got %b expected %b", bus.SDATA, e[0]); end
    e = exp_q.pop_front(); tests_run++;
    if (bus.POS0 !== e) begin fails++; $display("FAIL midshift_reset_pos0: got %h expected %h", bus.POS0, e); end
    reset = 1'b0;
    bus.SHFT0 = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h00);
    bus.LD1n = 1'b0; tick(); bus.LD1n = 1'b1;
    bus.SHFT0 = 1'b0; tick();
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front(); tests_run++;
      if (bus.SDATA !== e[0]) begin
        fails++; $display("FAIL post_reset_sr_bit%0d: got %b expected %b", i, bus.SDATA, e[0]);
      end
      ck1_edge();
    end
    bus.SHFT0 = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ce    = 1'b1;
    drive_idle();
    test_reset();
    test_forward();
    test_ce_gating();
    test_wrap();
    test_load_shift();
    test_load_clear();
    test_illegal();
    test_div4();
    test_both_shift_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
